// File: rtl/blink_monitor.sv
// Blink input monitor: synchronizes blink_in, measures the toggle interval, checks it against EXP_HALF+/-TOL and tracks lock.
// Optional loss-of-signal timeout is built when BLINK_MONITOR_TIMEOUT_EN is defined.
module blink_monitor #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int EXP_HALF   = CLK_FREQ / 4,
  parameter int TOL        = EXP_HALF / 16,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 2 * EXP_HALF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blink_in,
  output logic [31:0] half_period,
  output logic        meas_valid,
  output logic        in_tol,
  output logic        locked,
  output logic        timeout
);

  localparam logic [1:0] SEEK   = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]         state;
  logic               s1, s2, s3;
  logic               toggle;
  logic [31:0]        cnt;
  logic               cnt_sat;
  logic [31:0]        meas;
  logic signed [32:0] diff;
  logic [32:0]        mag;
  logic               meas_tol;
  logic [7:0]         good_cnt;
  logic [7:0]         good_next;
  logic               lock_hit;
  logic               to_hit;

  assign toggle    = s2 ^ s3;
  assign cnt_sat   = &cnt;
  // A saturated counter is reported as-is rather than wrapping to zero.
  assign meas      = cnt_sat ? '1 : cnt + 32'd1;
  assign diff      = $signed({1'b0, meas}) - $signed(33'(EXP_HALF));
  assign mag       = diff[32] ? 33'(-diff) : 33'(diff);
  assign meas_tol  = !cnt_sat && (mag <= 33'(TOL));
  assign good_next = good_cnt + 8'd1;
  assign lock_hit  = (good_next == 8'(LOCK_COUNT));

`ifdef BLINK_MONITOR_TIMEOUT_EN
  assign to_hit = (state != SEEK) && !toggle && (cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)          timeout <= 1'b0;
    else if (toggle)  timeout <= 1'b0;
    else if (to_hit)  timeout <= 1'b1;
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      cnt         <= '0;
      state       <= SEEK;
      good_cnt    <= '0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      in_tol      <= 1'b0;
      locked      <= 1'b0;
    end else begin
      s1         <= blink_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;

      if (toggle)        cnt <= '0;
      else if (!cnt_sat) cnt <= cnt + 32'd1;

      case (state)
        SEEK: begin
          if (toggle) state <= TRACK;
        end
        TRACK, LOCKED: begin
          if (toggle) begin
            half_period <= meas;
            in_tol      <= meas_tol;
            meas_valid  <= 1'b1;
            if (meas_tol) begin
              if (state == TRACK) begin
                good_cnt <= good_next;
                if (lock_hit) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end else begin
              good_cnt <= '0;
              state    <= TRACK;
              locked   <= 1'b0;
            end
          end else if (to_hit) begin
            state    <= SEEK;
            locked   <= 1'b0;
            good_cnt <= '0;
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_monitor.sv
// Scoreboard bench for blink_monitor: each driven toggle pushes its expected measurement, the monitor pops on meas_valid.
module tb_blink_monitor;

  localparam int EXP_HALF = 16;
  localparam int TOL      = 1;
  localparam int LOCKN    = 4;
  localparam int TMO      = 32;
`ifdef BLINK_MONITOR_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        blink_in = 1'b0;
  logic [31:0] half_period;
  logic        meas_valid;
  logic        in_tol;
  logic        locked;
  logic        timeout;

  blink_monitor #(
    .CLK_FREQ  (64),
    .EXP_HALF  (EXP_HALF),
    .TOL       (TOL),
    .LOCK_COUNT(LOCKN),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .blink_in   (blink_in),
    .half_period(half_period),
    .meas_valid (meas_valid),
    .in_tol     (in_tol),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] hp;
    logic        tol;
    logic        lock;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // model state
  bit m_seek = 1'b1;
  int m_good = 0;
  bit m_lock = 1'b0;
  int last = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_meas_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("meas_cycle", 32'(cyc), 32'(e.cyc));
        check("half_period", half_period, e.hp);
        check("in_tol", {31'd0, in_tol}, {31'd0, e.tol});
        check("locked", {31'd0, locked}, {31'd0, e.lock});
      end
    end
  end

  task automatic model_toggle();
    int iv;
    bit tol;
    exp_t e;
    iv = cyc - last;
    if (m_seek) begin
      m_seek = 1'b0;
    end else if (TO_ON && iv > TMO) begin
      m_good = 0;
      m_lock = 1'b0;
    end else begin
      tol = (iv >= EXP_HALF - TOL) && (iv <= EXP_HALF + TOL);
      if (tol) begin
        if (!m_lock) begin
          m_good++;
          if (m_good == LOCKN) m_lock = 1'b1;
        end
      end else begin
        m_good = 0;
        m_lock = 1'b0;
      end
      e.cyc = cyc + 3;
      e.hp = 32'(iv);
      e.tol = tol;
      e.lock = m_lock;
      sb.push_back(e);
    end
    last = cyc;
  endtask

  task automatic tog_at(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
    blink_in = ~blink_in;
    model_toggle();
  endtask

  task automatic tog(input int n);
    tog_at(last + n);
  endtask

  task automatic wait_neg(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_seek = 1'b1;
    m_good = 0;
    m_lock = 1'b0;
    last = cyc;
    // a high input at release ramps the synchronizer and acts as the first edge
    if (blink_in) m_seek = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_half_period"}, half_period, 32'd0);
    check({tag, "_meas_valid"}, {31'd0, meas_valid}, 32'd0);
    check({tag, "_in_tol"}, {31'd0, in_tol}, 32'd0);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
  endtask

  int p;

  initial begin
    // reset held three cycles while the input toggles, ending high
    repeat (3) begin
      @(posedge clk);
      #1;
      blink_in = ~blink_in;
    end
    @(negedge clk);
    check_idle("reset");
    release_rst();

    // nominal: ramp edge is the first edge, 4 good intervals then lock
    repeat (5) tog(16);

    // tolerance boundaries and relock
    tog(15);
    tog(17);
    tog(14);
    tog(18);
    repeat (4) tog(16);
    tog(18);
    repeat (4) tog(16);

    // minimum measurable interval
    tog(1);
    tog(1);
    repeat (4) tog(16);

    // static input after lock
    p = last;
    wait_neg(p + 34);
    check("pre_timeout_flag", {31'd0, timeout}, 32'd0);
    check("pre_timeout_locked", {31'd0, locked}, 32'd1);
    wait_neg(p + 35);
    check("timeout_flag", {31'd0, timeout}, {31'd0, TO_ON});
    check("timeout_locked", {31'd0, locked}, {31'd0, !TO_ON});
    tog(40);
    p = last;
    wait_neg(p + 2);
    check("timeout_sticky", {31'd0, timeout}, {31'd0, TO_ON});
    wait_neg(p + 3);
    check("timeout_cleared", {31'd0, timeout}, 32'd0);
    repeat (4) tog(16);

    // mid-run reset while locked
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_locked", {31'd0, locked}, 32'd1);
    rst = 1'b1;
    blink_in = 1'b0;
    release_rst();
    @(negedge clk);
    check_idle("midrun_reset");
    repeat (4) tog(16);
    wait_neg(last + 4);
    check("no_lock_after_4", {31'd0, locked}, 32'd0);
    tog(16);

    repeat (10) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
